// File: rtl/hps_terminal_fifo.sv
// HPS-side Avalon-MM slave bridging CPU accesses to the core instruction bus:
// a write window feeds a FIFO drained onto wr/wr_busy, rd_valid captures fill a readback RAM.
`timescale 1ns/1ps
module hps_terminal_fifo #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int WR_DEPTH = 16,
    parameter int WR_BASE  = 100,
    parameter int RD_BASE  = 300
) (
    input  logic                s_clk,
    input  logic                s_reset,
    input  logic                s_write,
    input  logic                s_read,
    input  logic [ADDR_W-1:0]   s_address,
    input  logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W-1:0]   s_readdata,
    output logic                main_reset_n,
    output logic                wr,
    input  logic                wr_busy,
    output logic [DATA_W+31:0]  wr_instruction,
    output logic                rd,
    input  logic                rd_valid,
    input  logic [DATA_W+31:0]  rd_instruction
);

    localparam int IW        = DATA_W + 32;
    localparam int PW        = $clog2(WR_DEPTH);
    localparam int LW        = PW + 1;
    localparam int RAM_DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(32'd0);
    localparam logic [ADDR_W-1:0] A_CLEAR  = ADDR_W'(32'd1);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(32'd2);
    localparam logic [ADDR_W-1:0] A_LEVEL  = ADDR_W'(32'd3);
    localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(32'd4);
    localparam logic [ADDR_W-1:0] WR_LO    = ADDR_W'(WR_BASE);
    localparam logic [ADDR_W-1:0] RD_LO    = ADDR_W'(RD_BASE);
    localparam logic [LW-1:0]     LVL_FULL = LW'(WR_DEPTH);
    localparam logic [LW-1:0]     LVL_ONE  = LW'(32'd1);
    localparam logic [PW-1:0]     PTR_ONE  = PW'(32'd1);

    typedef enum logic [1:0] {DR_IDLE, DR_ISSUE, DR_GAP} drain_state_t;
    typedef enum logic       {RB_WAIT, RB_HOLD}          rb_state_t;

    // The address field of an instruction is always 16 bits wide, zero-extended.
    function automatic logic [IW-1:0] pack_instr(input logic [DATA_W-1:0] data,
                                                  input logic [ADDR_W-1:0] addr);
        logic [15:0] addr16;
        addr16 = 16'(addr);
        return {data, 16'h0000, addr16};
    endfunction

    logic                ctrl_r;
    logic                overflow_r;
    logic [31:0]         rd_count_r;
    logic [DATA_W-1:0]   readdata_r;
    logic [LW-1:0]       level_r;
    logic [PW-1:0]       wp_r;
    logic [PW-1:0]       rp_r;
    logic [IW-1:0]       fifo_mem_r [WR_DEPTH];
    logic [DATA_W-1:0]   rb_ram_r [RAM_DEPTH];
    logic                wr_r;
    logic [IW-1:0]       wr_instr_r;
    logic                rd_r;
    drain_state_t        drain_state_r;
    drain_state_t        drain_next_s;
    rb_state_t           rb_state_r;
    rb_state_t           rb_next_s;

    logic                wr_en_s;
    logic                in_wr_win_s;
    logic                in_rd_win_s;
    logic                clr_ovf_s;
    logic                clr_cnt_s;
    logic                push_s;
    logic                pop_s;
    logic                accept_s;
    logic                ovf_set_s;
    logic                full_s;
    logic                empty_s;
    logic                capture_s;
    logic [DATA_W-1:0]   reg_rdata_s;

    // Slave address decode; a simultaneous read suppresses the write.
    always_comb begin
        wr_en_s     = s_write && !s_read;
        in_wr_win_s = (s_address >= WR_LO) && (s_address < RD_LO);
        in_rd_win_s = (s_address >= RD_LO);
        clr_ovf_s   = wr_en_s && (s_address == A_CLEAR) && s_writedata[0];
        clr_cnt_s   = wr_en_s && (s_address == A_CLEAR) && s_writedata[1];
        full_s      = (level_r == LVL_FULL);
        empty_s     = (level_r == {LW{1'b0}});
        push_s      = wr_en_s && in_wr_win_s && ctrl_r;
        accept_s    = push_s && (!full_s || pop_s);
        ovf_set_s   = push_s && full_s && !pop_s;
    end

    // Register-file read mux for the non-RAM part of the map.
    always_comb begin
        reg_rdata_s = {DATA_W{1'b0}};
        case (s_address)
            A_CTRL:   reg_rdata_s = DATA_W'(ctrl_r);
            A_STATUS: reg_rdata_s = DATA_W'({overflow_r, full_s, empty_s});
            A_LEVEL:  reg_rdata_s = DATA_W'(level_r);
            A_COUNT:  reg_rdata_s = DATA_W'(rd_count_r);
            default:  reg_rdata_s = {DATA_W{1'b0}};
        endcase
    end

    // Drain FSM next state; the core's busy flag only matters while idle.
    always_comb begin
        drain_next_s = drain_state_r;
        pop_s        = 1'b0;
        if (s_reset || !ctrl_r) begin
            drain_next_s = DR_IDLE;
        end else begin
            case (drain_state_r)
                DR_IDLE: begin
                    if (!empty_s && !wr_busy) begin
                        drain_next_s = DR_ISSUE;
                        pop_s        = 1'b1;
                    end else begin
                        drain_next_s = DR_IDLE;
                    end
                end
                DR_ISSUE: drain_next_s = DR_GAP;
                DR_GAP:   drain_next_s = DR_IDLE;
                default:  drain_next_s = DR_IDLE;
            endcase
        end
    end

    // Readback FSM next state; HOLD keeps a held rd_valid from double-capturing.
    always_comb begin
        rb_next_s = rb_state_r;
        capture_s = 1'b0;
        if (s_reset || !ctrl_r) begin
            rb_next_s = RB_WAIT;
        end else begin
            case (rb_state_r)
                RB_WAIT: begin
                    if (rd_valid) begin
                        rb_next_s = RB_HOLD;
                        capture_s = 1'b1;
                    end else begin
                        rb_next_s = RB_WAIT;
                    end
                end
                RB_HOLD: rb_next_s = RB_WAIT;
                default: rb_next_s = RB_WAIT;
            endcase
        end
    end

    // FSM state registers.
    always_ff @(posedge s_clk) begin
        if (s_reset) begin
            drain_state_r <= DR_IDLE;
            rb_state_r    <= RB_WAIT;
        end else begin
            drain_state_r <= drain_next_s;
            rb_state_r    <= rb_next_s;
        end
    end

    // FIFO pointers and level; soft reset flushes the queue.
    always_ff @(posedge s_clk) begin
        if (s_reset || !ctrl_r) begin
            wp_r    <= {PW{1'b0}};
            rp_r    <= {PW{1'b0}};
            level_r <= {LW{1'b0}};
        end else begin
            if (accept_s) begin
                wp_r <= wp_r + PTR_ONE;
            end
            if (pop_s) begin
                rp_r <= rp_r + PTR_ONE;
            end
            case ({accept_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge s_clk) begin
        if (accept_s) begin
            fifo_mem_r[wp_r] <= pack_instr(s_writedata, s_address);
        end
    end

    // Readback RAM, deliberately not cleared by reset.
    always_ff @(posedge s_clk) begin
        if (capture_s) begin
            rb_ram_r[rd_instruction[ADDR_W-1:0]] <= rd_instruction[IW-1:32];
        end
    end

    // Instruction-bus strobes and the issued instruction.
    always_ff @(posedge s_clk) begin
        if (s_reset) begin
            wr_r       <= 1'b0;
            rd_r       <= 1'b0;
            wr_instr_r <= {IW{1'b0}};
        end else begin
            wr_r <= pop_s;
            rd_r <= capture_s;
            if (pop_s) begin
                wr_instr_r <= fifo_mem_r[rp_r];
            end
        end
    end

    // Control, sticky status and readback counter; clearing the count beats a capture.
    always_ff @(posedge s_clk) begin
        if (s_reset) begin
            ctrl_r     <= 1'b0;
            overflow_r <= 1'b0;
            rd_count_r <= 32'd0;
        end else begin
            if (wr_en_s && (s_address == A_CTRL)) begin
                ctrl_r <= s_writedata[0];
            end
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (clr_ovf_s) begin
                overflow_r <= 1'b0;
            end
            if (clr_cnt_s) begin
                rd_count_r <= 32'd0;
            end else if (capture_s) begin
                rd_count_r <= rd_count_r + 32'd1;
            end
        end
    end

    // Registered read data, held between reads.
    always_ff @(posedge s_clk) begin
        if (s_reset) begin
            readdata_r <= {DATA_W{1'b0}};
        end else if (s_read) begin
            if (in_rd_win_s) begin
                readdata_r <= rb_ram_r[s_address];
            end else begin
                readdata_r <= reg_rdata_s;
            end
        end
    end

    assign s_readdata     = readdata_r;
    assign main_reset_n   = ctrl_r;
    assign wr             = wr_r;
    assign wr_instruction = wr_instr_r;
    assign rd             = rd_r;

endmodule
